// File: rtl/speed_pulse_mt_counter_module_pkg.sv
// -----------------------------------------------------------------------------
// speed_pulse_mt_counter_module_pkg
// Shared definitions for the M/T speed-pulse counter:
//   - interface widths (26-bit time/dividend, 8-bit edge count, 3-bit Hall)
//   - FSM state encoding
//   - Hall forward-sequence table (1-3-2-6-4-5-1) and its inverse
//   - default dividend scale and the M1 * scale helper
// -----------------------------------------------------------------------------
package speed_pulse_mt_counter_module_pkg;

    localparam int CNT_W  = 26;
    localparam int M1_W   = 8;
    localparam int HALL_W = 3;

    localparam int DEFAULT_DIVIDEND_SCALE = 390625;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_WAIT_EDGE,
        ST_OUTPUT
    } mt_state_t;

    // Next code when rotating forward.
    function automatic logic [HALL_W-1:0] hall_fwd_next(input logic [HALL_W-1:0] code);
        case (code)
            3'd1:    return 3'd3;
            3'd3:    return 3'd2;
            3'd2:    return 3'd6;
            3'd6:    return 3'd4;
            3'd4:    return 3'd5;
            3'd5:    return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    // Next code when rotating in reverse.
    function automatic logic [HALL_W-1:0] hall_fwd_prev(input logic [HALL_W-1:0] code);
        case (code)
            3'd1:    return 3'd5;
            3'd3:    return 3'd1;
            3'd2:    return 3'd3;
            3'd6:    return 3'd2;
            3'd4:    return 3'd6;
            3'd5:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic hall_is_legal(input logic [HALL_W-1:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

    // M1 never exceeds M1_MAX, so the truncated 26-bit product never wraps.
    function automatic logic [CNT_W-1:0] scale_dividend(input logic [M1_W-1:0] m1,
                                                        input logic [CNT_W-1:0] scale);
        return CNT_W'(m1) * scale;
    endfunction

endpackage

// File: rtl/speed_pulse_mt_counter_module_hall_decoder.sv
// -----------------------------------------------------------------------------
// hall_edge_direction_decoder
// Synchronizes the raw Hall inputs, tracks the last legal code and derives
// the per-edge strobes used by the M/T counter.
// Ports:
//   clk            in   1  system clock
//   reset          in   1  synchronous, active-high reset
//   hall_raw       in   3  raw Hall {C,B,A}, asynchronous to clk
//   edge_strobe    out  1  new legal code differing from the last legal code
//   reverse_strobe out  1  edge that is a single step against 'direction'
//   direction      out  1  0 = forward, 1 = reverse (registered)
//   fault          out  1  one-cycle pulse on entering an illegal code
// -----------------------------------------------------------------------------
module hall_edge_direction_decoder
    import speed_pulse_mt_counter_module_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [HALL_W-1:0] hall_raw,
    output logic              edge_strobe,
    output logic              reverse_strobe,
    output logic              direction,
    output logic              fault
);

    logic [HALL_W-1:0] sync_q [SYNC_STAGES];
    logic [HALL_W-1:0] hall_s;
    logic [HALL_W-1:0] hall_prev;
    logic [HALL_W-1:0] last_code;

    logic code_legal;
    logic code_change;
    logic step_fwd;
    logic step_rev;

    assign hall_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        code_legal     = hall_is_legal(hall_s);
        // With no legal code remembered yet (after reset) the first legal
        // sample only seeds last_code; it is not an edge.
        code_change    = code_legal && (last_code != '0) && (hall_s != last_code);
        step_fwd       = code_change && (hall_s == hall_fwd_next(last_code));
        step_rev       = code_change && (hall_s == hall_fwd_prev(last_code));
        edge_strobe    = code_change;
        reverse_strobe = (step_fwd && direction) || (step_rev && !direction);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, which is what makes the
    // synchronizer chain shift by exactly one stage per clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the synchronizer chain is cleared as well; leaving it
            // unreset would let a pre-reset Hall code reach the edge logic
            // after release and look like a fresh edge.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            hall_prev <= '0;
            last_code <= '0;
            direction <= 1'b0;
            fault     <= 1'b0;
        end else begin
            sync_q[0] <= hall_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hall_prev <= hall_s;
            if (code_legal) begin
                last_code <= hall_s;
            end
            // Non-adjacent jumps leave the direction alone.
            if (step_fwd) begin
                direction <= 1'b0;
            end else if (step_rev) begin
                direction <= 1'b1;
            end
            // Pulse once when the input moves into an illegal code, not for
            // every cycle it stays there.
            fault <= !code_legal && (hall_s != hall_prev);
        end
    end

endmodule

// File: rtl/speed_pulse_mt_counter_module.sv
// -----------------------------------------------------------------------------
// speed_pulse_mt_counter_module
// Producer side of the M/T speed measurement: counts Hall edges (M1) and
// sys_clk cycles (M2) over a gated window and hands M2, M1*DIVIDEND_SCALE and
// the rotation direction to the speed calculation stage with a valid strobe.
// Ports:
//   sys_clk                         in   1   system clock
//   reset                           in   1   synchronous, active-high reset
//   hall_in                         in   3   raw Hall {C,B,A}
//   speed_pluse_time_cnt_out        out  26  M2 of the last closed window
//   speed_pluse_count_dividend_out  out  26  M1 * DIVIDEND_SCALE
//   speed_cnt_valid_out             out  1   one-cycle strobe, data valid with it
//   rotation_direction_out          out  1   0 = forward, 1 = reverse
//   hall_fault_out                  out  1   one-cycle strobe on code 000/111
// -----------------------------------------------------------------------------
module speed_pulse_mt_counter_module
    import speed_pulse_mt_counter_module_pkg::*;
#(
    parameter int GATE_CYCLES    = 2_500_000,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int DIVIDEND_SCALE = DEFAULT_DIVIDEND_SCALE,
    parameter int M1_MAX         = 171,
    parameter int SYNC_STAGES    = 2
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [HALL_W-1:0] hall_in,
    output logic [CNT_W-1:0]  speed_pluse_time_cnt_out,
    output logic [CNT_W-1:0]  speed_pluse_count_dividend_out,
    output logic              speed_cnt_valid_out,
    output logic              rotation_direction_out,
    output logic              hall_fault_out
);

    localparam logic [CNT_W-1:0] GATE_C    = CNT_W'(GATE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] SCALE_C   = CNT_W'(DIVIDEND_SCALE);
    localparam logic [M1_W-1:0]  M1_MAX_C  = M1_W'(M1_MAX);
    localparam logic [CNT_W-1:0] M2_ONE    = CNT_W'(1);
    localparam logic [M1_W-1:0]  M1_ONE    = M1_W'(1);

    logic edge_strobe;
    logic reverse_strobe;

    hall_edge_direction_decoder #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_hall_decoder (
        .clk            (sys_clk),
        .reset          (reset),
        .hall_raw       (hall_in),
        .edge_strobe    (edge_strobe),
        .reverse_strobe (reverse_strobe),
        .direction      (rotation_direction_out),
        .fault          (hall_fault_out)
    );

    mt_state_t        state, state_next;
    logic [M1_W-1:0]  m1, m1_next, m1_inc;
    logic [CNT_W-1:0] m2, m2_next;
    logic [M1_W-1:0]  cap_m1, cap_m1_next;
    logic [CNT_W-1:0] cap_m2, cap_m2_next;
    logic             timed_out, timed_out_next;
    logic             counting;

    // M2 is loaded with 1 on the cycle after the opening edge, so on any later
    // cycle it equals the distance in cycles from the opening edge.
    always_comb begin
        // NOTE: every signal driven here gets a default first; any path that
        // skipped an assignment would otherwise infer a latch.
        state_next     = state;
        m1_next        = m1;
        m2_next        = m2;
        cap_m1_next    = cap_m1;
        cap_m2_next    = cap_m2;
        timed_out_next = timed_out;
        m1_inc         = m1 + M1_ONE;

        // The OUTPUT cycle that follows a normal close already belongs to the
        // next (contiguous) window, so counting carries on through it. After
        // a timeout there is no window and OUTPUT behaves like IDLE.
        counting = (state == ST_MEASURE) || (state == ST_WAIT_EDGE) ||
                   ((state == ST_OUTPUT) && !timed_out);

        if (!counting) begin
            timed_out_next = 1'b0;
            state_next     = ST_IDLE;
            if (edge_strobe) begin
                state_next = ST_MEASURE;
                m1_next    = '0;
                m2_next    = M2_ONE;
            end
        end else begin
            m2_next    = m2 + M2_ONE;
            state_next = (m2 >= GATE_C) ? ST_WAIT_EDGE : ST_MEASURE;
            if (edge_strobe && reverse_strobe) begin
                // Reversal: discard the window and reopen at this edge.
                state_next = ST_MEASURE;
                m1_next    = '0;
                m2_next    = M2_ONE;
            end else if (edge_strobe) begin
                if ((m2 >= GATE_C) || (m1_inc == M1_MAX_C)) begin
                    cap_m2_next = m2;
                    cap_m1_next = m1_inc;
                    m1_next     = '0;
                    m2_next     = M2_ONE;
                    state_next  = ST_OUTPUT;
                end else begin
                    m1_next = m1_inc;
                end
            end else if (m2 >= TIMEOUT_C) begin
                // Edge has priority above, so this only fires on a quiet cycle.
                cap_m2_next    = TIMEOUT_C;
                cap_m1_next    = '0;
                m1_next        = '0;
                m2_next        = '0;
                timed_out_next = 1'b1;
                state_next     = ST_OUTPUT;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            m1        <= '0;
            m2        <= '0;
            cap_m1    <= '0;
            cap_m2    <= '0;
            timed_out <= 1'b0;
        end else begin
            state     <= state_next;
            m1        <= m1_next;
            m2        <= m2_next;
            cap_m1    <= cap_m1_next;
            cap_m2    <= cap_m2_next;
            timed_out <= timed_out_next;
        end
    end

    // Output stage: loaded during the OUTPUT cycle, so valid lands two cycles
    // after the closing edge and the data holds until the next valid.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            speed_pluse_time_cnt_out       <= '0;
            speed_pluse_count_dividend_out <= '0;
            speed_cnt_valid_out            <= 1'b0;
        end else begin
            speed_cnt_valid_out <= (state == ST_OUTPUT);
            if (state == ST_OUTPUT) begin
                speed_pluse_time_cnt_out       <= cap_m2;
                speed_pluse_count_dividend_out <= scale_dividend(cap_m1, SCALE_C);
            end
        end
    end

endmodule

// File: tb/tb_speed_pulse_mt_counter_module.sv
`timescale 1ns/1ps
module tb_speed_pulse_mt_counter_module;

    localparam int GATE      = 4500;
    localparam int TIMEOUT   = 20000;
    localparam int M1MAX     = 171;
    localparam int SCALE     = 390625;
    localparam int IN_LAT    = 2;   // hall_in change -> edge strobe (two synchronizer flops)
    localparam int VALID_LAT = 2;   // closing edge strobe -> valid

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [2:0]  hall_in = 3'd1;
    logic [25:0] tcnt, dvd;
    logic        valid, dir, fault;

    speed_pulse_mt_counter_module #(
        .GATE_CYCLES    (GATE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .DIVIDEND_SCALE (SCALE),
        .M1_MAX         (M1MAX),
        .SYNC_STAGES    (2)
    ) dut (
        .sys_clk                        (sys_clk),
        .reset                          (reset),
        .hall_in                        (hall_in),
        .speed_pluse_time_cnt_out       (tcnt),
        .speed_pluse_count_dividend_out (dvd),
        .speed_cnt_valid_out            (valid),
        .rotation_direction_out         (dir),
        .hall_fault_out                 (fault)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int cyc;
        int tcnt;
        int dvd;
        int dir;
    } vrec_t;

    vrec_t obs_q[$];
    vrec_t exp_q[$];
    int    fault_seen = 0;
    int    fault_exp  = 0;

    always @(negedge sys_clk) begin
        if (!reset && valid) obs_q.push_back('{cyc, int'(tcnt), int'(dvd), int'(dir)});
        if (!reset && fault) fault_seen++;
    end

    // ---------------- reference model (event level) ----------------
    int fwd_seq [6] = '{1, 3, 2, 6, 4, 5};
    int m_open, m_s0, m_m1, m_dir, m_last;

    function automatic int pos_of(input int code);
        for (int i = 0; i < 6; i++) if (fwd_seq[i] == code) return i;
        return -1;
    endfunction

    task automatic model_reset(input int code);
        m_open = 0; m_s0 = 0; m_m1 = 0; m_dir = 0; m_last = code;
    endtask

    // Emit a timeout record if the open window aged past TIMEOUT before time t.
    task automatic model_advance(input int t);
        if (m_open != 0 && t > m_s0 + TIMEOUT) begin
            exp_q.push_back('{m_s0 + TIMEOUT + VALID_LAT, TIMEOUT, 0, m_dir});
            m_open = 0;
        end
    endtask

    // New Hall value x becomes visible to the edge logic at cycle s.
    task automatic model_code(input int s, input int x);
        int d;
        int rev_flag;
        model_advance(s);
        if (x == 0 || x == 7) begin
            fault_exp++;
            return;
        end
        if (m_last == 0) begin
            m_last = x;
            return;
        end
        if (x == m_last) return;
        d = (pos_of(x) - pos_of(m_last) + 6) % 6;
        rev_flag = ((d == 1) && m_dir == 1) || ((d == 5) && m_dir == 0);
        if (d == 1) m_dir = 0;
        else if (d == 5) m_dir = 1;
        m_last = x;
        if (m_open == 0) begin
            m_open = 1; m_s0 = s; m_m1 = 0;
            return;
        end
        if (rev_flag) begin
            m_s0 = s; m_m1 = 0;
            return;
        end
        m_m1++;
        if (s - m_s0 >= GATE || m_m1 == M1MAX) begin
            exp_q.push_back('{s + VALID_LAT, s - m_s0, m_m1 * SCALE, m_dir});
            m_s0 = s; m_m1 = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    int hpos;
    int ddir;

    task automatic drive(input logic [2:0] x, input int gap);
        @(negedge sys_clk);
        hall_in = x;
        model_code(cyc + IN_LAT, int'(x));
        repeat (gap - 1) @(negedge sys_clk);
    endtask

    task automatic step_fwd(input int gap);
        hpos = (hpos + 1) % 6;
        drive(3'(fwd_seq[hpos]), gap);
    endtask

    task automatic step_rev(input int gap);
        hpos = (hpos + 5) % 6;
        drive(3'(fwd_seq[hpos]), gap);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tcnt"},  tcnt,  0);
        check({tag, "_dvd"},   dvd,   0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_dir"},   dir,   0);
        check({tag, "_fault"}, fault, 0);
    endtask

    initial begin
        int r;
        int n;
        hpos = $urandom_range(0, 5);
        ddir = 0;
        hall_in = 3'(fwd_seq[hpos]);
        reset = 1'b1;
        repeat (4) @(negedge sys_clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        model_reset(fwd_seq[hpos]);
        repeat (20) @(negedge sys_clk);

        // A: forward every 1000 cycles, one 111 glitch inside a step.
        for (int i = 0; i < 11; i++) begin
            if (i == 3) begin
                step_fwd(500);
                drive(3'b111, 5);
                drive(3'(fwd_seq[hpos]), 495);
            end else begin
                step_fwd(1000);
            end
        end

        // B: reverse every 1000 cycles (first step aborts the open window).
        for (int i = 0; i < 7; i++) step_rev(1000);

        // C: forward every 10 cycles, windows close on the M1 limit.
        for (int i = 0; i < 400; i++) step_fwd(10);

        // D: randomized steps, reversals, jumps and illegal glitches.
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 99);
            n = $urandom_range(10, 700);
            if (r < 75) begin
                if (ddir != 0) step_rev(n); else step_fwd(n);
            end else if (r < 83) begin
                ddir ^= 1;
                if (ddir != 0) step_rev(n); else step_fwd(n);
            end else if (r < 92) begin
                hpos = (hpos + 2 + $urandom_range(0, 2)) % 6;
                drive(3'(fwd_seq[hpos]), n);
            end else begin
                drive(($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000, 3);
                if (ddir != 0) step_rev(n); else step_fwd(n);
            end
        end

        // E: three edges then silence -> timeout, then a fresh window.
        step_fwd(1000);
        step_fwd(1000);
        step_fwd(TIMEOUT + 100);
        for (int i = 0; i < 6; i++) step_fwd(1000);

        // F: reset roughly 2000 cycles into a window.
        repeat (1000) @(negedge sys_clk);
        reset = 1'b1;
        @(negedge sys_clk);
        check_outputs_zero("mid_reset");
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;
        model_reset(fwd_seq[hpos]);
        repeat (20) @(negedge sys_clk);
        for (int i = 0; i < 7; i++) step_fwd(1000);

        repeat (50) @(negedge sys_clk);
        model_advance(cyc - VALID_LAT);

        // Scoreboard comparison.
        check("valid_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("valid%0d_cycle", i), obs_q[i].cyc,  exp_q[i].cyc);
            check($sformatf("valid%0d_tcnt", i),  obs_q[i].tcnt, exp_q[i].tcnt);
            check($sformatf("valid%0d_dvd", i),   obs_q[i].dvd,  exp_q[i].dvd);
            check($sformatf("valid%0d_dir", i),   obs_q[i].dir,  exp_q[i].dir);
        end
        check("fault_pulses", fault_seen, fault_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
